flash_burst_reader: RTL and testbench
=====================================

// Module: flash_burst_reader
// PURPOSE
//  Parametrised read-only master for the external weight flash (ce/oe/we/address/data bus).
//  Takes burst requests (start address, word count) and issues one flash read at a time
//  with a programmable access wait. Captured words are buffered in an output FIFO with a
//  valid/ready stream, so the ALU/controller can stream biases and weights under backpressure.
// PARAMETERS
//  ADDR_WIDTH  16  flash address width; address wraps modulo 2**ADDR_WIDTH
//  DATA_WIDTH  16  flash word width
//  LEN_WIDTH    9  burst length field width (max burst 2**LEN_WIDTH-1 words)
//  FIFO_DEPTH   8  output FIFO entries, power of 2, >=2
//  READ_WAIT    2  cycles from address/ce/oe valid to data sample, >=1
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  req_valid  in   1           burst request present
//  req_ready  out  1           request accepted when req_valid & req_ready at clk edge
//  req_addr   in   ADDR_WIDTH  first word address
//  req_len    in   LEN_WIDTH   number of words; 0 = no-op
//  abort      in   1           cancel burst, flush FIFO
//  ce         out  1           flash chip enable, active-high, registered
//  oe         out  1           flash output enable, active-high, registered
//  we         out  1           flash write enable; constant 0
//  address    out  ADDR_WIDTH  flash address, registered
//  data       in   DATA_WIDTH  flash read data, sampled on final wait cycle
//  out_valid  out  1           FIFO head valid
//  out_ready  in   1           consumer pops head when out_valid & out_ready
//  out_data   out  DATA_WIDTH  FIFO head word
//  out_last   out  1           head is final word of its burst
//  busy       out  1           state != IDLE
//  count      out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  Reset: state IDLE; ce=oe=we=0; address=0; FIFO empty; out_valid=out_last=0; count=0; busy=0.
//  req_ready = (state==IDLE) & ~abort. Accept latches addr, remaining=req_len.
//  FSM: IDLE -> ISSUE on accept with req_len!=0; req_len==0 stays IDLE, no bus activity.
//   ISSUE: if count (after any same-cycle pop) < FIFO_DEPTH: register address=cur_addr,
//     ce=oe=1, wait_cnt=READ_WAIT-1 -> WAIT; else hold ISSUE with ce=oe=0 (stall).
//   WAIT: ce/oe/address held; wait_cnt decrements; at wait_cnt==0 push data into FIFO
//     (out_last = remaining==1), cur_addr+=1 (wrap), remaining-=1;
//     remaining becomes 0 -> IDLE (ce=oe=0 next cycle), else -> ISSUE.
//  Exactly one read in flight; the space check at ISSUE guarantees the push never overflows.
//  Latency: accept at edge E0; ce/oe/address valid from E1; data sampled at E(READ_WAIT+1);
//   out_valid high after that edge if FIFO was empty. Throughput 1 word per READ_WAIT+1 cycles.
//  FIFO: registered head, no bypass. Push+pop in same cycle: count unchanged. Pop when
//   empty ignored. Words and out_last emerge in address order.
//  abort (any state, priority over everything): next edge state=IDLE, ce=oe=0, FIFO
//   flushed (count=0, out_valid=0); in-flight read discarded; req_valid same cycle not accepted.
//  rst mid-burst: immediate return to reset values; burst lost, no partial words retained.
// TESTING
//  1 Model data[i]=0x0100+i, READ_WAIT=2, addr 0 len 37, out_ready=1 -> words 0x0100..0x0124
//    in order, out_last only on 37th, first out_valid 3 edges after accept, req_ready=1 after.
//  2 Backpressure: out_ready=0, len 20 -> count saturates at 8, ce=oe=0 while stalled, no lost
//    or overwritten word; then out_ready=1 -> remaining 12 words arrive intact, count returns 0.
//  3 Wrap: addr 0xFFFE len 4 -> address sequence FFFE, FFFF, 0000, 0001; out_last on 4th.
//  4 abort after 5th push of len-20 burst -> next cycle out_valid=0, count=0, ce=0, busy=0;
//    new req addr 0x0010 len 2 returns only 0x0110, 0x0111.
//  5 req_len=0 -> accepted, no ce pulse, out_valid stays 0, busy stays 0.
//  6 rst asserted during WAIT -> ce=oe=0, count=0 immediately; READ_WAIT=1 build repeats test 1
//    with one word every 2 cycles.

Source files
------------

// File: rtl/flash_burst_reader.sv
// Burst read master for the external weight flash.
// It issues one flash read at a time with a programmable access wait. Captured words
// are buffered in an output FIFO that drives a valid/ready stream with a last-word flag.
module flash_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned READ_WAIT  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [LEN_WIDTH-1:0]              req_len,
  input  logic                              abort,
  output logic                              ce,
  output logic                              oe,
  output logic                              we,
  output logic [ADDR_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH-1:0]             data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining, remaining_d;
  logic [WAIT_W-1:0]     wait_cnt, wait_cnt_d;
  logic                  ce_d;
  logic [ADDR_WIDTH-1:0] address_d;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_d;

  logic accept, pop, push, space, read_done;

  // Handshake and FIFO control terms
  assign req_ready = (state == S_IDLE) & ~abort;
  assign accept    = req_valid & req_ready;
  assign pop       = out_valid & out_ready;
  assign space     = (count - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);
  assign read_done = (state == S_WAIT) && (wait_cnt == '0);
  assign push      = read_done & ~abort;
  assign count_d   = count + CNT_W'(push) - CNT_W'(pop);
  assign we        = 1'b0;
  assign out_data  = mem[rd_ptr];
  assign out_last  = out_valid & mem_last[rd_ptr];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept && (req_len != '0)) state_d = S_ISSUE;
        S_ISSUE: if (space) state_d = S_WAIT;
        S_WAIT:  if (wait_cnt == '0)
                   state_d = (remaining == LEN_WIDTH'(1)) ? S_IDLE : S_ISSUE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the bus strobes, address and burst bookkeeping
  always_comb begin
    ce_d        = ce;
    address_d   = address;
    cur_addr_d  = cur_addr;
    remaining_d = remaining;
    wait_cnt_d  = wait_cnt;
    if (abort) begin
      ce_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_addr_d  = req_addr;
            remaining_d = req_len;
          end
        end
        S_ISSUE: begin
          if (space) begin
            ce_d       = 1'b1;
            address_d  = cur_addr;
            wait_cnt_d = WAIT_W'(READ_WAIT - 1);
          end else begin
            ce_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            ce_d        = 1'b0;
            cur_addr_d  = cur_addr + ADDR_WIDTH'(1);
            remaining_d = remaining - LEN_WIDTH'(1);
          end else begin
            wait_cnt_d = wait_cnt - WAIT_W'(1);
          end
        end
        default: ce_d = 1'b0;
      endcase
    end
  end

  // Registered bus outputs and burst counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce        <= 1'b0;
      oe        <= 1'b0;
      address   <= '0;
      busy      <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      ce        <= ce_d;
      oe        <= ce_d;
      address   <= address_d;
      busy      <= (state_d != S_IDLE);
      cur_addr  <= cur_addr_d;
      remaining <= remaining_d;
      wait_cnt  <= wait_cnt_d;
    end
  end

  // Output FIFO storage; abort flushes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      mem_last  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (abort) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr]      <= data;
        mem_last[wr_ptr] <= (remaining == LEN_WIDTH'(1));
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_d;
      out_valid <= (count_d != '0);
    end
  end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench for flash_burst_reader; the flash model returns 0x0100 + address.
module tb_flash_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic [8:0]  req_len = '0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;

  logic        req_ready, ce, oe, we, out_valid, out_last, busy;
  logic [15:0] address, data, out_data;
  logic [3:0]  count;

  logic        req_ready_1, ce_1, oe_1, we_1, out_valid_1, out_last_1, busy_1;
  logic [15:0] address_1, data_1, out_data_1;
  logic [3:0]  count_1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign data   = address + 16'h0100;
  assign data_1 = address_1 + 16'h0100;

  flash_burst_reader #(.READ_WAIT(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .abort(abort), .ce(ce), .oe(oe),
    .we(we), .address(address), .data(data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .count(count)
  );

  flash_burst_reader #(.READ_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_1),
    .req_addr(req_addr), .req_len(req_len), .abort(abort), .ce(ce_1), .oe(oe_1),
    .we(we_1), .address(address_1), .data(data_1), .out_valid(out_valid_1),
    .out_ready(out_ready), .out_data(out_data_1), .out_last(out_last_1),
    .busy(busy_1), .count(count_1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int k = 0; k < 200 && busy; k++) tick();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    compared++;
    if ({ce, oe, we, out_valid, out_last, busy} !== 6'b0) begin
      mismatched++; $display("FAIL reset_strobes: ce oe we ov ol busy=%b want 000000",
                             {ce, oe, we, out_valid, out_last, busy});
    end
    compared++;
    if (address !== 16'h0000) begin mismatched++; $display("FAIL reset_address: got %h want 0000", address); end
    compared++;
    if (count !== 4'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", count); end
    rst = 1'b0;
    tick();
    compared++;
    if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_basic;
    int n;
    out_ready = 1'b1;
    req_addr = 16'h0000; req_len = 9'd37; req_valid = 1'b1;
    compared++;
    if (req_ready !== 1'b1) begin mismatched++; $display("FAIL basic_req_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    compared++;
    if (busy !== 1'b1 || ce !== 1'b0) begin mismatched++; $display("FAIL basic_after_accept: busy=%b ce=%b want 1 0", busy, ce); end
    tick();
    compared++;
    if (ce !== 1'b1 || oe !== 1'b1 || address !== 16'h0000 || out_valid !== 1'b0) begin
      mismatched++; $display("FAIL basic_first_issue: ce=%b oe=%b addr=%h ov=%b want 1 1 0000 0", ce, oe, address, out_valid);
    end
    tick();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_data !== 16'h0100) begin
      mismatched++; $display("FAIL basic_first_word: ov=%b data=%h want 1 0100", out_valid, out_data);
    end
    n = 0;
    for (int c = 0; c < 200 && n < 37; c++) begin
      if (out_valid) begin
        compared++;
        if (out_data !== 16'h0100 + 16'(n) || out_last !== (n == 36)) begin
          mismatched++; $display("FAIL basic_word%0d: data=%h last=%b want %h %b", n, out_data, out_last, 16'h0100 + 16'(n), (n == 36));
        end
        n++;
      end
      tick();
    end
    compared++;
    if (n != 37) begin mismatched++; $display("FAIL basic_word_count: got %0d want 37", n); end
    wait_idle();
    compared++;
    if (req_ready !== 1'b1 || count !== 4'd0) begin
      mismatched++; $display("FAIL basic_end: req_ready=%b count=%0d want 1 0", req_ready, count);
    end
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    req_addr = 16'h0040; req_len = 9'd20; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 60; c++) tick();
    compared++;
    if (count !== 4'd8) begin mismatched++; $display("FAIL bp_count_full: got %0d want 8", count); end
    compared++;
    if (ce !== 1'b0 || oe !== 1'b0 || busy !== 1'b1) begin
      mismatched++; $display("FAIL bp_stall: ce=%b oe=%b busy=%b want 0 0 1", ce, oe, busy);
    end
    compared++;
    if (out_valid !== 1'b1 || out_data !== 16'h0140) begin
      mismatched++; $display("FAIL bp_head: ov=%b data=%h want 1 0140", out_valid, out_data);
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      if (out_valid) begin
        compared++;
        if (out_data !== 16'h0140 + 16'(n) || out_last !== (n == 19)) begin
          mismatched++; $display("FAIL bp_word%0d: data=%h last=%b want %h %b", n, out_data, out_last, 16'h0140 + 16'(n), (n == 19));
        end
        n++;
      end
      tick();
    end
    compared++;
    if (n != 20) begin mismatched++; $display("FAIL bp_word_count: got %0d want 20", n); end
    wait_idle();
    compared++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      mismatched++; $display("FAIL bp_drained: count=%0d ov=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_a [4];
    int na, nw;
    logic prev_ce;
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    out_ready = 1'b1;
    req_addr = 16'hFFFE; req_len = 9'd4; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    na = 0; nw = 0; prev_ce = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ce && !prev_ce) begin
        compared++;
        if (na > 3 || address !== exp_a[na & 3]) begin
          mismatched++; $display("FAIL wrap_addr%0d: got %h want %h", na, address, exp_a[na & 3]);
        end
        na++;
      end
      if (out_valid) begin
        compared++;
        if (nw > 3 || out_data !== exp_a[nw & 3] + 16'h0100 || out_last !== (nw == 3)) begin
          mismatched++; $display("FAIL wrap_word%0d: data=%h last=%b want %h %b", nw, out_data, out_last, exp_a[nw & 3] + 16'h0100, (nw == 3));
        end
        nw++;
      end
      prev_ce = ce;
      tick();
    end
    compared++;
    if (na != 4 || nw != 4) begin mismatched++; $display("FAIL wrap_counts: reads=%0d words=%0d want 4 4", na, nw); end
    wait_idle();
  endtask

  task automatic test_abort;
    int n;
    out_ready = 1'b0;
    req_addr = 16'h0000; req_len = 9'd20; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 100 && count != 4'd5; k++) tick();
    compared++;
    if (count !== 4'd5) begin mismatched++; $display("FAIL abort_fill: count=%0d want 5", count); end
    abort = 1'b1;
    req_addr = 16'h0010; req_len = 9'd2; req_valid = 1'b1;
    compared++;
    if (req_ready !== 1'b0) begin mismatched++; $display("FAIL abort_req_ready: got %b want 0", req_ready); end
    tick();
    compared++;
    if (out_valid !== 1'b0 || count !== 4'd0 || ce !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL abort_flush: ov=%b count=%0d ce=%b busy=%b want 0 0 0 0", out_valid, count, ce, busy);
    end
    abort = 1'b0;
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL abort_new_accept: busy=%b want 1", busy); end
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        compared++;
        if (out_data !== 16'h0110 + 16'(n) || out_last !== (n == 1)) begin
          mismatched++; $display("FAIL abort_word%0d: data=%h last=%b want %h %b", n, out_data, out_last, 16'h0110 + 16'(n), (n == 1));
        end
        n++;
      end
      tick();
    end
    compared++;
    if (n != 2) begin mismatched++; $display("FAIL abort_word_count: got %0d want 2", n); end
  endtask

  task automatic test_zero_len;
    logic seen_ce, seen_ov, seen_busy;
    out_ready = 1'b1;
    req_addr = 16'h0033; req_len = 9'd0; req_valid = 1'b1;
    compared++;
    if (req_ready !== 1'b1) begin mismatched++; $display("FAIL zero_req_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    seen_ce = 1'b0; seen_ov = 1'b0; seen_busy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen_ce   |= ce;
      seen_ov   |= out_valid;
      seen_busy |= busy;
      tick();
    end
    compared++;
    if ({seen_ce, seen_ov, seen_busy} !== 3'b000) begin
      mismatched++; $display("FAIL zero_activity: ce ov busy seen=%b want 000", {seen_ce, seen_ov, seen_busy});
    end
  endtask

  task automatic test_reset_mid;
    logic seen_ov;
    out_ready = 1'b0;
    req_addr = 16'h0020; req_len = 9'd10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 60 && !(count >= 4'd2 && ce); k++) tick();
    compared++;
    if (!(count >= 4'd2 && ce === 1'b1)) begin mismatched++; $display("FAIL rstmid_setup: count=%0d ce=%b want >=2 1", count, ce); end
    rst = 1'b1;
    #1;
    compared++;
    if (ce !== 1'b0 || oe !== 1'b0 || count !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL rstmid_immediate: ce=%b oe=%b count=%0d ov=%b busy=%b want 0 0 0 0 0", ce, oe, count, out_valid, busy);
    end
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    seen_ov = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen_ov |= out_valid;
      tick();
    end
    compared++;
    if (seen_ov !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL rstmid_no_residue: ov_seen=%b busy=%b want 0 0", seen_ov, busy);
    end
  endtask

  task automatic test_read_wait1;
    int n, last_c;
    out_ready = 1'b1;
    req_addr = 16'h0000; req_len = 9'd37; req_valid = 1'b1;
    compared++;
    if (req_ready_1 !== 1'b1) begin mismatched++; $display("FAIL rw1_req_ready: got %b want 1", req_ready_1); end
    tick();
    req_valid = 1'b0;
    tick();
    compared++;
    if (ce_1 !== 1'b1 || out_valid_1 !== 1'b0) begin
      mismatched++; $display("FAIL rw1_first_issue: ce=%b ov=%b want 1 0", ce_1, out_valid_1);
    end
    tick();
    compared++;
    if (out_valid_1 !== 1'b1 || out_data_1 !== 16'h0100) begin
      mismatched++; $display("FAIL rw1_first_word: ov=%b data=%h want 1 0100", out_valid_1, out_data_1);
    end
    n = 0; last_c = 0;
    for (int c = 0; c < 150 && n < 37; c++) begin
      if (out_valid_1) begin
        compared++;
        if (out_data_1 !== 16'h0100 + 16'(n) || out_last_1 !== (n == 36) || (n > 0 && c - last_c != 2)) begin
          mismatched++; $display("FAIL rw1_word%0d: data=%h last=%b gap=%0d want %h %b 2", n, out_data_1, out_last_1, c - last_c, 16'h0100 + 16'(n), (n == 36));
        end
        last_c = c;
        n++;
      end
      tick();
    end
    compared++;
    if (n != 37) begin mismatched++; $display("FAIL rw1_word_count: got %0d want 37", n); end
    wait_idle();
    compared++;
    if (busy_1 !== 1'b0 || count_1 !== 4'd0) begin
      mismatched++; $display("FAIL rw1_end: busy=%b count=%0d want 0 0", busy_1, count_1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_zero_len();
    test_reset_mid();
    test_read_wait1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
